// File: rtl/net_tx_mii.sv
// net_tx_mii: pops 32-bit fifo words and sends one Ethernet frame per start on MII TX.
// Define NET_TX_FCS_EN to append a CRC-32 FCS after the payload.
module net_tx_mii #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int LEN_WIDTH   = 11,
  parameter int IPG_NIBBLES = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun,
  input  logic [ADDR_WIDTH-1:0] fifo_data_cnt,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_Rready,
  output logic                  tx_en,
  output logic [3:0]            txd,
  output logic                  tx_er
);
  localparam int CW = $clog2(IPG_NIBBLES > 16 ? IPG_NIBBLES : 16);
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, FCS, IPG, ABORT} state_t;
  state_t state, state_nx;
  logic [LEN_WIDTH-1:0] len, byte_cnt;
  logic                 nib;
  logic [1:0]           biw;
  logic [CW-1:0]        cnt;
  logic [7:0]           cur_byte;
  logic                 last_byte, starve, accept;
  assign cur_byte  = fifo_rdata[{biw, 3'b000} +: 8];
  assign last_byte = byte_cnt == len - LEN_WIDTH'(1);
  // a word may only be started when the fifo actually holds it
  assign starve    = state == DATA && biw == 2'd0 && !nib && fifo_data_cnt == '0;
  assign accept    = state == IDLE && start && frame_len != '0;
  assign busy      = state != IDLE;
`ifdef NET_TX_FCS_EN
  localparam state_t TAIL = FCS;
  logic [31:0] crc, fcs;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  assign fcs = ~crc;
  always_ff @(posedge clk or posedge rst)
    if (rst) crc <= '0;
    else if (accept) crc <= '1;
    else if (state == DATA && !starve && nib) crc <= crc_byte(crc, cur_byte);
`else
  localparam state_t TAIL = IPG;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx    = state;
    tx_en       = 1'b0;
    txd         = 4'h0;
    tx_er       = 1'b0;
    fifo_Rready = 1'b0;
    underrun    = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: state_nx = accept ? PRE : IDLE;
      PRE: begin
        tx_en    = 1'b1;
        txd      = 4'h5;
        state_nx = cnt == CW'(14) ? SFD : PRE;
      end
      SFD: begin
        tx_en    = 1'b1;
        txd      = 4'hD;
        state_nx = DATA;
      end
      DATA: begin
        tx_en       = 1'b1;
        tx_er       = starve;
        underrun    = starve;
        txd         = starve ? 4'h0 : nib ? cur_byte[7:4] : cur_byte[3:0];
        fifo_Rready = nib && (biw == 2'd3 || last_byte);
        state_nx    = starve ? ABORT : (nib && last_byte) ? TAIL : DATA;
      end
`ifdef NET_TX_FCS_EN
      FCS: begin
        tx_en    = 1'b1;
        txd      = fcs[{cnt[2:0], 2'b00} +: 4];
        state_nx = cnt == CW'(7) ? IPG : FCS;
      end
`endif
      IPG: begin
        done     = cnt == CW'(IPG_NIBBLES - 1);
        state_nx = done ? IDLE : IPG;
      end
      ABORT: state_nx = IPG;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      len      <= '0;
      byte_cnt <= '0;
      nib      <= 1'b0;
      biw      <= 2'd0;
      cnt      <= '0;
    end else begin
      cnt <= state_nx != state ? '0 : (state == PRE || state == FCS || state == IPG) ? cnt + CW'(1) : cnt;
      if (accept) begin
        len      <= frame_len;
        byte_cnt <= '0;
        nib      <= 1'b0;
        biw      <= 2'd0;
      end else if (state == DATA && !starve) begin
        nib <= ~nib;
        if (nib) begin
          byte_cnt <= byte_cnt + LEN_WIDTH'(1);
          biw      <= biw + 2'd1;
        end
      end
    end
endmodule

// File: tb/tb_net_tx_mii.sv
// tb_net_tx_mii: scoreboard bench; stimulus queues expected nibbles and done gaps, a monitor checks them.
module tb_net_tx_mii;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] frame_len = '0;
  logic        busy, done, underrun, fifo_Rready, tx_en, tx_er;
  logic [5:0]  fifo_data_cnt;
  logic [31:0] fifo_rdata;
  logic [3:0]  txd;
  logic [31:0] mem [16];
  int          rd_ptr = 0, wr_ptr = 0;
  int          total = 0, bad = 0, done_seen = 0, low_cnt = 0;
  typedef struct packed {logic [3:0] d; logic er; logic pop;} rec_t;
  rec_t        exp_q [$];
  int          done_q [$];

  always #5 clk = ~clk;

  net_tx_mii dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .busy(busy), .done(done),
    .underrun(underrun), .fifo_data_cnt(fifo_data_cnt), .fifo_rdata(fifo_rdata),
    .fifo_Rready(fifo_Rready), .tx_en(tx_en), .txd(txd), .tx_er(tx_er)
  );

  assign fifo_rdata    = mem[rd_ptr % 16];
  assign fifo_data_cnt = 6'(wr_ptr - rd_ptr);
  always @(posedge clk) if (fifo_Rready) rd_ptr <= rd_ptr + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int hv(input byte c);
    if (c >= 8'h61) return c - 8'h61 + 10;
    if (c >= 8'h41) return c - 8'h41 + 10;
    return c - 8'h30;
  endfunction

`ifdef NET_TX_FCS_EN
  function automatic string tail(input string pay);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    string       s;
    c = '1;
    s = "";
    for (int i = 0; i < pay.len() / 2; i++) begin
      b = 8'(hv(pay[2*i]) + 16 * hv(pay[2*i+1]));
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    c = ~c;
    for (int k = 0; k < 8; k++) s = {s, $sformatf("%h", c[4*k +: 4])};
    return s;
  endfunction
`else
  function automatic string tail(input string pay);
    return (pay.len() > 0) ? "" : "";
  endfunction
`endif

  task automatic expect_frame(input string pay, input string fcs, input logic [63:0] popm, input bit und, input int gap);
    for (int i = 0; i < 15; i++) exp_q.push_back('{4'h5, 1'b0, 1'b0});
    exp_q.push_back('{4'hD, 1'b0, 1'b0});
    for (int i = 0; i < pay.len(); i++) exp_q.push_back('{4'(hv(pay[i])), 1'b0, popm[i]});
    if (und) exp_q.push_back('{4'h0, 1'b1, 1'b0});
    for (int i = 0; i < fcs.len(); i++) exp_q.push_back('{4'(hv(fcs[i])), 1'b0, 1'b0});
    done_q.push_back(gap);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr++;
  endtask

  task automatic pulse_start(input logic [10:0] l);
    start     = 1'b1;
    frame_len = l;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_seen < target && n < 2000) begin
      tick();
      n++;
    end
    chk("done_timeout", 32'(done_seen >= target), 1);
    tick();
    chk("busy_after_done", busy, 0);
  endtask

  // monitor: every tx_en cycle must match the head of the expected queue
  always @(negedge clk) if (!rst) begin
    if (tx_en) begin
      low_cnt = 0;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tx: got txd %0h want tx_en low", txd);
      end else begin
        rec_t r;
        r = exp_q.pop_front();
        chk("txd", txd, r.d);
        chk("tx_er", tx_er, r.er);
        chk("underrun", underrun, r.er);
        chk("pop", fifo_Rready, r.pop);
      end
    end else begin
      low_cnt++;
      chk("quiet", {tx_er, underrun, fifo_Rready, txd}, 0);
    end
    if (done) begin
      done_seen++;
      chk("busy_at_done", busy, 1);
      chk("frame_left", exp_q.size(), 0);
      if (done_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want 0");
      end else chk("done_gap", low_cnt, done_q.pop_front());
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_en", tx_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pop", fifo_Rready, 0);
    chk("rst_txd", txd, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0;
    tick();
    // single full word
    push_word(32'h44332211);
    expect_frame("11223344", tail("11223344"), 64'h80, 1'b0, 24);
    pulse_start(11'd4);
    chk("busy_on_start", busy, 1);
    wait_done(1);
    chk("fifo_a", fifo_data_cnt, 0);
    // partial final word
    push_word(32'h44332211);
    push_word(32'h88776655);
    expect_frame("1122334455", tail("1122334455"), 64'h280, 1'b0, 24);
    pulse_start(11'd5);
    wait_done(2);
    chk("fifo_b", fifo_data_cnt, 0);
    // underrun on the second word
    push_word(32'h44332211);
    expect_frame("11223344", "", 64'h80, 1'b1, 25);
    pulse_start(11'd8);
    wait_done(3);
    chk("fifo_c", fifo_data_cnt, 0);
    // "123456789"
    push_word(32'h34333231);
    push_word(32'h38373635);
    push_word(32'h00000039);
`ifdef NET_TX_FCS_EN
    expect_frame("132333435363738393", "62934FBC", 64'h28080, 1'b0, 24);
`else
    expect_frame("132333435363738393", "", 64'h28080, 1'b0, 24);
`endif
    pulse_start(11'd9);
    wait_done(4);
    chk("fifo_d", fifo_data_cnt, 0);
    // starts during PRE, during IPG and with zero length are ignored
    push_word(32'h44332211);
    expect_frame("11223344", tail("11223344"), 64'h80, 1'b0, 24);
    pulse_start(11'd4);
    repeat (5) tick();
    pulse_start(11'd4);
`ifdef NET_TX_FCS_EN
    repeat (28) tick();
`else
    repeat (20) tick();
`endif
    chk("in_ipg", {busy, tx_en}, 2'b10);
    pulse_start(11'd4);
    wait_done(5);
    pulse_start(11'd0);
    chk("len0_busy", busy, 0);
    repeat (40) tick();
    chk("no_extra_done", done_seen, 5);
    chk("no_extra_pop", rd_ptr, wr_ptr);
    // reset in the middle of the payload
    push_word(32'h44332211);
    expect_frame("11223344", tail("11223344"), 64'h80, 1'b0, 24);
    pulse_start(11'd4);
    repeat (19) tick();
    chk("pre_rst_tx_en", tx_en, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_en", tx_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pop", fifo_Rready, 0);
    exp_q.delete();
    done_q.delete();
    wr_ptr = rd_ptr;
    tick();
    rst = 1'b0;
    tick();
    push_word(32'hDDCCBBAA);
    expect_frame("AABBCCDD", tail("AABBCCDD"), 64'h80, 1'b0, 24);
    pulse_start(11'd4);
    wait_done(6);
    chk("fifo_e", fifo_data_cnt, 0);
    chk("exp_q_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
